// File: rtl/pb_fill_req_scheduler_if.sv
// Fill-request and memory-read handshake bundle for pb_fill_req_scheduler.
// The slave modport is the scheduler's view; the master modport is the requester/memory side.
interface pb_fill_req_scheduler_if #(
  parameter int BITS_INPUT_ADDR_SLOW_BLK = 5
);
  logic                                send_fill_req;
  logic [BITS_INPUT_ADDR_SLOW_BLK-1:0] bin_to_fill_addr;
  logic                                fill_req_accept_ready;
  logic                                mem_rd_valid;
  logic [BITS_INPUT_ADDR_SLOW_BLK-1:0] mem_rd_addr;
  logic                                mem_rd_ready;
  logic                                mem_rsp_valid;
  logic                                fill_done;
  logic [BITS_INPUT_ADDR_SLOW_BLK-1:0] fill_done_addr;

  modport slave (
    input  send_fill_req, bin_to_fill_addr, mem_rd_ready, mem_rsp_valid,
    output fill_req_accept_ready, mem_rd_valid, mem_rd_addr, fill_done, fill_done_addr
  );

  modport master (
    output send_fill_req, bin_to_fill_addr, mem_rd_ready, mem_rsp_valid,
    input  fill_req_accept_ready, mem_rd_valid, mem_rd_addr, fill_done, fill_done_addr
  );
endinterface

// File: rtl/pb_fill_req_scheduler.sv
// Queues page-buffer fill requests, issues them as bounded in-flight memory reads, retires on last beat.
// Optional macro FILL_REQ_DEDUP_EN drops requests whose address is already queued or in flight.
`ifndef MODE_WORK
`define MODE_WORK 1'b1
`endif

module pb_fill_req_scheduler #(
  parameter int BITS_INPUT_ADDR_SLOW_BLK = 5,
  parameter int FIFO_DEPTH               = 4,
  parameter int MAX_OUTSTANDING          = 2,
  parameter int BEATS_PER_FILL           = 4
) (
  input  logic clk_slow,
  input  logic rst,
  input  logic unit_en,
  input  logic mode,
  output logic busy,
  pb_fill_req_scheduler_if.slave bus
);
  localparam int AW  = BITS_INPUT_ADDR_SLOW_BLK;
  localparam int QW  = $clog2(FIFO_DEPTH);
  localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW  = (BEATS_PER_FILL > 1) ? $clog2(BEATS_PER_FILL) : 1;

  logic [AW-1:0]  queue_mem [FIFO_DEPTH];
  logic [QW:0]    q_wr_ptr, q_rd_ptr;
  logic [AW-1:0]  flight_mem [MAX_OUTSTANDING];
  logic [OPW-1:0] f_wr_ptr, f_rd_ptr;
  logic [OCW-1:0] outstanding;
  logic [BW-1:0]  beat_cnt;

  logic global_en, q_empty, q_full, enq_fire, issue_fire, beat_fire, retire_fire;
  logic [AW-1:0] retire_addr;

  function automatic logic [OPW-1:0] flight_next(input logic [OPW-1:0] p);
    return (p == OPW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign global_en   = (mode == `MODE_WORK) && unit_en;
  assign q_empty     = (q_wr_ptr == q_rd_ptr);
  assign q_full      = (q_wr_ptr[QW] != q_rd_ptr[QW]) && (q_wr_ptr[QW-1:0] == q_rd_ptr[QW-1:0]);
  assign retire_addr = flight_mem[f_rd_ptr];

  assign bus.mem_rd_valid = global_en && !q_empty && (outstanding < OCW'(MAX_OUTSTANDING));
  assign bus.mem_rd_addr  = bus.mem_rd_valid ? queue_mem[q_rd_ptr[QW-1:0]] : '0;
  assign issue_fire       = bus.mem_rd_valid && bus.mem_rd_ready;
  assign beat_fire        = bus.mem_rsp_valid && (outstanding != '0);
  assign retire_fire      = beat_fire && (beat_cnt == BW'(BEATS_PER_FILL - 1));
  assign busy             = !q_empty || (outstanding != '0);

`ifdef FILL_REQ_DEDUP_EN
  // One bit per address: set while that address is queued or in flight.
  logic [2**AW-1:0] pending_map;
  logic             req_pending;

  assign req_pending               = pending_map[bus.bin_to_fill_addr];
  assign bus.fill_req_accept_ready = !rst && global_en && (!q_full || req_pending);
  assign enq_fire                  = bus.send_fill_req && bus.fill_req_accept_ready && !req_pending;

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      pending_map <= '0;
    end else begin
      if (retire_fire) pending_map[retire_addr] <= 1'b0;
      if (enq_fire)    pending_map[bus.bin_to_fill_addr] <= 1'b1;
    end
  end
`else
  assign bus.fill_req_accept_ready = !rst && global_en && !q_full;
  assign enq_fire                  = bus.send_fill_req && bus.fill_req_accept_ready;
`endif

  always_ff @(posedge clk_slow) begin
    if (enq_fire)   queue_mem[q_wr_ptr[QW-1:0]] <= bus.bin_to_fill_addr;
    if (issue_fire) flight_mem[f_wr_ptr]        <= bus.mem_rd_addr;
  end

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      q_wr_ptr <= '0;
      q_rd_ptr <= '0;
      f_wr_ptr <= '0;
      f_rd_ptr <= '0;
    end else begin
      if (enq_fire)    q_wr_ptr <= q_wr_ptr + 1'b1;
      if (issue_fire)  q_rd_ptr <= q_rd_ptr + 1'b1;
      if (issue_fire)  f_wr_ptr <= flight_next(f_wr_ptr);
      if (retire_fire) f_rd_ptr <= flight_next(f_rd_ptr);
    end
  end

  // Beats are only counted while something is in flight; strays are ignored.
  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      outstanding        <= '0;
      beat_cnt           <= '0;
      bus.fill_done      <= 1'b0;
      bus.fill_done_addr <= '0;
    end else begin
      case ({issue_fire, retire_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (beat_fire) beat_cnt <= retire_fire ? '0 : beat_cnt + 1'b1;
      bus.fill_done <= retire_fire;
      if (retire_fire) bus.fill_done_addr <= retire_addr;
    end
  end
endmodule

// File: tb/tb_pb_fill_req_scheduler.sv
// Randomized bench for pb_fill_req_scheduler against a queue-based reference model.
// The model follows FILL_REQ_DEDUP_EN when that macro is defined for the build.
`ifndef MODE_WORK
`define MODE_WORK 1'b1
`endif

module tb_pb_fill_req_scheduler;
  localparam int AW  = 5;
  localparam int FD  = 4;
  localparam int MO  = 2;
  localparam int BPF = 4;
`ifdef FILL_REQ_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic clk_slow = 1'b0;
  logic rst, unit_en, mode, busy;

  pb_fill_req_scheduler_if #(.BITS_INPUT_ADDR_SLOW_BLK(AW)) bus ();

  pb_fill_req_scheduler #(
    .BITS_INPUT_ADDR_SLOW_BLK(AW), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO), .BEATS_PER_FILL(BPF)
  ) dut (
    .clk_slow(clk_slow), .rst(rst), .unit_en(unit_en), .mode(mode), .busy(busy), .bus(bus)
  );

  always #5 clk_slow = ~clk_slow;

  int checks = 0;
  int errors = 0;
  int model_q[$];
  int model_flight[$];
  int model_beat = 0;
  bit model_done = 1'b0;
  int model_done_addr = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelPending(input int a);
    foreach (model_q[i]) if (model_q[i] == a) return 1'b1;
    foreach (model_flight[i]) if (model_flight[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clearModel();
    model_q.delete();
    model_flight.delete();
    model_beat = 0;
    model_done = 1'b0;
  endtask

  // One clock cycle: drive, check combinational and registered outputs, then advance the model.
  task automatic applyStimulus(input bit en, input bit md, input bit send, input int addr,
                               input bit rdy, input bit rsp);
    bit gen, pend, exp_ready, exp_valid, issue, retire, enq, beat;
    unit_en = en;
    mode = md;
    bus.send_fill_req = send;
    bus.bin_to_fill_addr = addr[AW-1:0];
    bus.mem_rd_ready = rdy;
    bus.mem_rsp_valid = rsp;
    #1;
    gen       = (md == `MODE_WORK) && en;
    pend      = DEDUP && modelPending(addr);
    exp_ready = gen && ((model_q.size() < FD) || pend);
    exp_valid = gen && (model_q.size() > 0) && (model_flight.size() < MO);
    checkOutput("ready", 32'(bus.fill_req_accept_ready), 32'(exp_ready));
    checkOutput("rd_valid", 32'(bus.mem_rd_valid), 32'(exp_valid));
    if (exp_valid) checkOutput("rd_addr", 32'(bus.mem_rd_addr), 32'(model_q[0]));
    checkOutput("busy", 32'(busy), 32'((model_q.size() > 0) || (model_flight.size() > 0)));
    checkOutput("fill_done", 32'(bus.fill_done), 32'(model_done));
    if (model_done) checkOutput("done_addr", 32'(bus.fill_done_addr), 32'(model_done_addr));
    issue  = exp_valid && rdy;
    beat   = rsp && (model_flight.size() > 0);
    retire = beat && (model_beat == BPF - 1);
    enq    = send && exp_ready && !pend;
    @(posedge clk_slow);
    model_done = retire;
    if (retire) begin
      model_done_addr = model_flight.pop_front();
      model_beat = 0;
    end else if (beat) begin
      model_beat++;
    end
    if (issue) model_flight.push_back(model_q.pop_front());
    if (enq) model_q.push_back(addr);
    #1;
  endtask

  task automatic doReset();
    unit_en = 1'b1;
    mode = `MODE_WORK;
    rst = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(bus.fill_req_accept_ready), 32'(0));
    checkOutput("rst_rd_valid", 32'(bus.mem_rd_valid), 32'(0));
    checkOutput("rst_rd_addr", 32'(bus.mem_rd_addr), 32'(0));
    checkOutput("rst_fill_done", 32'(bus.fill_done), 32'(0));
    checkOutput("rst_done_addr", 32'(bus.fill_done_addr), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    clearModel();
    @(negedge clk_slow);
    rst = 1'b0;
    @(posedge clk_slow);
    #1;
  endtask

  task automatic runRandom(input int n, input int p_send, input int p_rdy, input int p_rsp,
                           input int p_off, input int addr_max);
    for (int i = 0; i < n; i++) begin
      applyStimulus(($urandom_range(99) >= p_off), ($urandom_range(99) >= p_off / 2),
                    ($urandom_range(99) < p_send), int'($urandom_range(addr_max)),
                    ($urandom_range(99) < p_rdy), ($urandom_range(99) < p_rsp));
    end
  endtask

  initial begin
    rst = 1'b1;
    unit_en = 1'b1;
    mode = `MODE_WORK;
    bus.send_fill_req = 1'b0;
    bus.bin_to_fill_addr = '0;
    bus.mem_rd_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    #2;
    doReset();

    // single fill of address 5 through to retire and idle
    applyStimulus(1, 1, 1, 5, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < BPF; i++) applyStimulus(1, 1, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0);

    // back-to-back 1..5 while memory stalls, upstream holds until accepted
    for (int a = 1; a <= 5; a++) begin
      applyStimulus(1, 1, 1, a, 0, 0);
      if (a == 5) begin
        applyStimulus(1, 1, 1, 5, 0, 0);
        applyStimulus(1, 1, 1, 5, 1, 0);
        applyStimulus(1, 1, 1, 5, 0, 0);
      end
    end
    // in-flight bound: keep ready high with no responses, then retire one
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < BPF; i++) applyStimulus(1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 1, 0);

    // disabled mode: no issue, no accept, but responses still retire
    for (int i = 0; i < 2 * BPF + 2; i++) applyStimulus(1, ~`MODE_WORK, 1, 9, 1, 1);
    for (int i = 0; i < 3 * BPF + 6; i++) applyStimulus(1, 1, 0, 0, 1, 1);

    // duplicate address 7 before and after its retire
    applyStimulus(1, 1, 1, 7, 0, 0);
    applyStimulus(1, 1, 1, 7, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < BPF + 2; i++) applyStimulus(1, 1, 0, 0, 1, 1);
    applyStimulus(1, 1, 1, 7, 1, 0);
    for (int i = 0; i < BPF + 3; i++) applyStimulus(1, 1, 0, 0, 1, 1);

    // build 2 in flight plus queued entries, then reset mid-operation
    for (int a = 10; a < 14; a++) applyStimulus(1, 1, 1, a, 0, 0);
    applyStimulus(1, 1, 1, 14, 1, 0);
    applyStimulus(1, 1, 1, 15, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0);
    doReset();
    for (int i = 0; i < BPF + 1; i++) applyStimulus(1, 1, 0, 0, 0, 1);

    runRandom(600, 60, 70, 40, 6, 2**AW - 1);
    runRandom(600, 70, 50, 50, 4, 7);
    runRandom(300, 40, 90, 80, 20, 3);
    doReset();
    runRandom(300, 80, 30, 30, 0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
